// File: rtl/mgia_fetch_shifter.sv
// MGIA frame-buffer fetch and pixel shifter.
// Wishbone read master feeding a prefetch FIFO that drains through a 1/2/4 bpp shifter.
module mgia_fetch_shifter #(
    parameter int DW    = 16,
    parameter int AW    = 20,
    parameter int DEPTH = 8
) (
    input  logic          CLK_I_50MHZ,
    input  logic          RST_I,
    input  logic          FRAME_I,
    input  logic [AW-1:0] BASE_I,
    input  logic [AW-1:0] WORDS_I,
    input  logic [1:0]    MODE_I,
    input  logic          PIX_EN_I,
    output logic [AW-1:0] MGIA_ADR_O,
    output logic          MGIA_CYC_O,
    output logic          MGIA_STB_O,
    input  logic [DW-1:0] MGIA_DAT_I,
    input  logic          MGIA_ACK_I,
    output logic [3:0]    PIX_O,
    output logic          UNDERRUN_O
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam int PW   = $clog2(DW);

    logic            stb_q;
    logic [AW-1:0]   adr_q;
    logic [AW-1:0]   words_q;

    logic [DW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] wptr_q;
    logic [PTRW-1:0] rptr_q;
    logic [CW-1:0]   cnt_q;

    logic [DW-1:0]   word_q;
    logic [PW-1:0]   left_q;
    logic [1:0]      bpp_q;
    logic [3:0]      pix_q;
    logic            und_q;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            can_fetch;
    logic [DW-1:0]   head;

    // Top pixel of a word for a given depth, zero-extended to 4 bits.
    function automatic logic [3:0] top_bits(input logic [DW-1:0] w,
                                            input logic [1:0] m);
        case (m)
            2'd0:    return {3'b000, w[DW-1]};
            2'd1:    return {2'b00, w[DW-1:DW-2]};
            default: return w[DW-1:DW-4];
        endcase
    endfunction

    // Move the next pixel up into the MSB position.
    function automatic logic [DW-1:0] shl(input logic [DW-1:0] w,
                                          input logic [1:0] m);
        case (m)
            2'd0:    return w << 1;
            2'd1:    return w << 2;
            default: return w << 4;
        endcase
    endfunction

    // Pixels still to emit after the first one of a freshly loaded word.
    function automatic logic [PW-1:0] first_left(input logic [1:0] m);
        case (m)
            2'd0:    return PW'(DW - 1);
            2'd1:    return PW'(DW / 2 - 1);
            default: return PW'(DW / 4 - 1);
        endcase
    endfunction

    // A coincident FRAME_I or reset discards the acknowledged word.
    assign push       = stb_q & MGIA_ACK_I & ~FRAME_I & ~RST_I;
    assign fifo_empty = (cnt_q == '0);
    assign pop        = PIX_EN_I & ~FRAME_I & (left_q == '0) & ~fifo_empty;
    assign can_fetch  = ~stb_q & (cnt_q < CW'(DEPTH)) & (words_q != '0);
    assign head       = mem[rptr_q];

    assign MGIA_ADR_O = adr_q;
    assign MGIA_CYC_O = stb_q;
    assign MGIA_STB_O = stb_q;
    assign PIX_O      = pix_q;
    assign UNDERRUN_O = und_q;

    // Bus master: one read in flight, strobe drops for a cycle after each ack.
    always_ff @(posedge CLK_I_50MHZ) begin
        if (RST_I) begin
            stb_q   <= 1'b0;
            adr_q   <= '0;
            words_q <= '0;
        end else if (FRAME_I) begin
            stb_q   <= 1'b0;
            adr_q   <= BASE_I;
            words_q <= WORDS_I;
        end else if (stb_q && MGIA_ACK_I) begin
            stb_q   <= 1'b0;
            adr_q   <= adr_q + AW'(1);
            words_q <= words_q - AW'(1);
        end else if (can_fetch) begin
            stb_q   <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate them.
    always_ff @(posedge CLK_I_50MHZ) begin
        if (push)
            mem[wptr_q] <= MGIA_DAT_I;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK_I_50MHZ) begin
        if (RST_I || FRAME_I) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + PTRW'(1);
            if (pop)
                rptr_q <= rptr_q + PTRW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Pixel shifter: MSB-first, depth latched at each word load.
    always_ff @(posedge CLK_I_50MHZ) begin
        if (RST_I || FRAME_I) begin
            word_q <= '0;
            left_q <= '0;
            bpp_q  <= 2'd0;
            pix_q  <= 4'd0;
            und_q  <= 1'b0;
        end else if (PIX_EN_I) begin
            if (left_q != '0) begin
                pix_q  <= top_bits(word_q, bpp_q);
                word_q <= shl(word_q, bpp_q);
                left_q <= left_q - PW'(1);
            end else if (!fifo_empty) begin
                pix_q  <= top_bits(head, MODE_I);
                word_q <= shl(head, MODE_I);
                left_q <= first_left(MODE_I);
                bpp_q  <= MODE_I;
            end else begin
                pix_q  <= 4'd0;
                und_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mgia_fetch_shifter.sv
// Directed bench for mgia_fetch_shifter.
// Bus slave returns words from a small table indexed by the low address bits.
module tb_mgia_fetch_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic [19:0] base;
    logic [19:0] words;
    logic [1:0]  mode;
    logic        pix_en;
    logic [19:0] adr;
    logic        cyc;
    logic        stb;
    logic [15:0] dat;
    logic        ack;
    logic [3:0]  pix;
    logic        und;

    logic [15:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          reads  = 0;
    int          cyc_bad = 0;
    logic [19:0] rd_adr [$];

    always #10 clk = ~clk;

    assign dat = mem[adr[3:0]];

    mgia_fetch_shifter dut (
        .CLK_I_50MHZ (clk),
        .RST_I       (rst),
        .FRAME_I     (frame),
        .BASE_I      (base),
        .WORDS_I     (words),
        .MODE_I      (mode),
        .PIX_EN_I    (pix_en),
        .MGIA_ADR_O  (adr),
        .MGIA_CYC_O  (cyc),
        .MGIA_STB_O  (stb),
        .MGIA_DAT_I  (dat),
        .MGIA_ACK_I  (ack),
        .PIX_O       (pix),
        .UNDERRUN_O  (und)
    );

    // Log each completed bus read (ack while strobed, not killed).
    always @(posedge clk) begin
        if (!rst && !frame && stb && ack) begin
            reads++;
            rd_adr.push_back(adr);
        end
    end

    always @(negedge clk) begin
        if (cyc !== stb)
            cyc_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input logic [19:0] b, input logic [19:0] w);
        base  = b;
        words = w;
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic wait_stb();
        for (int i = 0; i < 20; i++) begin
            if (stb) break;
            tick();
        end
        chk("stb_up", stb, 1);
    endtask

    logic [3:0] exp_1bpp [16];
    logic [3:0] exp_4bpp [6];
    int         r0;

    initial begin
        exp_1bpp = '{1,1,1,1,0,0,0,0,1,0,1,0,0,0,0,0};
        exp_4bpp = '{4'h1,4'h2,4'h3,4'h4,4'hA,4'hB};
        for (int i = 0; i < 16; i++)
            mem[i] = 16'(i * 16'h1111);
        mem[0] = 16'hF0A0;
        mem[1] = 16'h1234;
        mem[2] = 16'hABCD;

        rst = 1'b1; frame = 1'b0; base = '0; words = '0;
        mode = 2'd0; pix_en = 1'b0; ack = 1'b0;
        tick(3);
        chk("rst_stb", stb, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_adr", adr, 0);
        chk("rst_pix", pix, 0);
        chk("rst_und", und, 0);
        rst = 1'b0;
        tick(2);
        chk("idle_stb", stb, 0);

        // Three-word frame, ack tied high.
        ack = 1'b1;
        start_frame(20'h00100, 20'd3);
        chk("frm_adr", adr, 20'h00100);
        tick(12);
        chk("rd_n", reads, 3);
        for (int i = 0; i < 3; i++)
            chk("rd_adr", (rd_adr.size() > i) ? rd_adr[i] : 20'hFFFFF,
                20'h00100 + 20'(i));
        chk("rd_stb_lo", stb, 0);
        chk("rd_adr_end", adr, 20'h00103);

        // 1bpp drain of 0xF0A0.
        mode = 2'd0;
        pix_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("px1", pix, exp_1bpp[i]);
        end

        // 4bpp drain of 0x1234 then 0xABCD.
        mode = 2'd2;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("px4", pix, exp_4bpp[i]);
        end
        pix_en = 1'b0;
        mode = 2'd0;
        tick();
        chk("px_hold", pix, 4'hB);
        pix_en = 1'b1;
        tick();
        chk("px4_c", pix, 4'hC);
        tick();
        chk("px4_d", pix, 4'hD);
        tick();
        chk("ur_pix", pix, 0);
        chk("ur_flag", und, 1);
        pix_en = 1'b0;
        tick(3);
        chk("ur_sticky", und, 1);

        // New frame clears underrun; new mode applies to the new word.
        start_frame(20'h00100, 20'd1);
        chk("frm_und", und, 0);
        chk("frm_pix", pix, 0);
        tick(4);
        pix_en = 1'b1;
        tick();
        chk("mode_new", pix, 4'h1);
        tick();
        chk("mode_new2", pix, 4'h1);
        pix_en = 1'b0;

        // Ack withheld: immediate underrun, strobe and address hold.
        ack = 1'b0;
        start_frame(20'h00040, 20'd5);
        pix_en = 1'b1;
        tick();
        chk("wh_pix", pix, 0);
        chk("wh_und", und, 1);
        tick(5);
        chk("wh_und2", und, 1);
        chk("wh_stb", stb, 1);
        chk("wh_adr", adr, 20'h00040);

        // FRAME_I with ack and pixel strobe on a live transfer.
        r0 = reads;
        base = 20'h00340; words = 20'd4;
        frame = 1'b1; ack = 1'b1;
        tick();
        frame = 1'b0; ack = 1'b0;
        chk("fk_stb", stb, 0);
        chk("fk_adr", adr, 20'h00340);
        chk("fk_pix", pix, 0);
        chk("fk_und", und, 0);
        tick();
        chk("fk_empty", und, 1);
        chk("fk_reads", reads, r0);
        wait_stb();

        // Reset with ack on a live transfer, overriding FRAME_I.
        rst = 1'b1; frame = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; frame = 1'b0; pix_en = 1'b0;
        chk("rk_stb", stb, 0);
        chk("rk_adr", adr, 0);
        chk("rk_und", und, 0);
        tick(5);
        chk("rk_idle", stb, 0);
        chk("rk_reads", reads, r0);
        pix_en = 1'b1;
        tick();
        chk("rk_empty", und, 1);
        pix_en = 1'b0;

        // Long frame: fetch stops at FIFO depth, one pop buys one read.
        r0 = reads;
        start_frame(20'h00200, 20'd20);
        tick(30);
        chk("full_n", reads - r0, 8);
        chk("full_stb", stb, 0);
        chk("full_adr", adr, 20'h00208);
        mode = 2'd0;
        pix_en = 1'b1;
        tick();
        chk("full_px", pix, 4'h1);
        tick(15);
        pix_en = 1'b0;
        tick(6);
        chk("pop_n", reads - r0, 9);
        chk("pop_adr", adr, 20'h00209);
        chk("pop_stb", stb, 0);

        // Zero-length frame.
        r0 = reads;
        start_frame(20'h00500, 20'd0);
        tick(8);
        chk("zero_n", reads, r0);
        chk("zero_stb", stb, 0);
        chk("zero_adr", adr, 20'h00500);

        chk("cyc_eq_stb", cyc_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mgia_fetch_shifter.md
MGIA_FETCH_SHIFTER -- requirements
Module: mgia_fetch_shifter

Interface
REQ-001 SHALL have parameter DW, default 16, meaning frame-buffer data word width (multiple of 4).
REQ-002 SHALL have parameter AW, default 20, meaning word-address width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning prefetch FIFO depth in words (power of 2, >=2).
REQ-004 SHALL have port CLK_I_50MHZ  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST_I  in  1  synchronous, active-high reset.
REQ-006 SHALL have port FRAME_I  in  1  start-of-frame pulse; restarts fetch and flushes the FIFO.
REQ-007 SHALL have port BASE_I  in  AW  frame-buffer base word address, sampled on FRAME_I.
REQ-008 SHALL have port WORDS_I  in  AW  words per frame, sampled on FRAME_I.
REQ-009 SHALL have port MODE_I  in  2  pixel depth: 0=1bpp, 1=2bpp, 2=4bpp, 3=4bpp.
REQ-010 SHALL have port PIX_EN_I  in  1  pixel strobe; one pixel consumed per asserted cycle.
REQ-011 SHALL have port MGIA_ADR_O  out  AW  Wishbone read address.
REQ-012 SHALL have port MGIA_CYC_O  out  1  Wishbone cycle.
REQ-013 SHALL have port MGIA_STB_O  out  1  Wishbone strobe.
REQ-014 SHALL have port MGIA_DAT_I  in  DW  Wishbone read data.
REQ-015 SHALL have port MGIA_ACK_I  in  1  Wishbone acknowledge.
REQ-016 SHALL have port PIX_O  out  4  current pixel, zero-extended to 4 bits.
REQ-017 SHALL have port UNDERRUN_O  out  1  sticky underrun flag.

Function
REQ-018 Fetch: Wishbone classic read master, one transfer in flight, no write-enable output; CYC_O equal to STB_O at all times.
REQ-019 Fetch: STB_O SHALL rise only when FIFO count < DEPTH and words-remaining > 0, and SHALL hold with ADR_O stable until the ACK_I cycle.
REQ-020 Fetch: on an ACK_I cycle: DAT_I pushed into the FIFO, ADR_O incremented by 1 (wrap modulo 2^AW), words-remaining decremented, STB_O dropped for at least one cycle.
REQ-021 Fetch: ACK_I while STB_O is low SHALL be ignored.
REQ-022 FRAME_I SHALL load ADR_O=BASE_I and words-remaining=WORDS_I, empty the FIFO, deassert STB/CYC that cycle (abandoning any in-flight transfer; a coincident ACK_I is discarded), clear shifter count and UNDERRUN_O; fetch resumes the next cycle.
REQ-023 WORDS_I=0 on FRAME_I SHALL result in no bus cycles that frame.
REQ-024 FIFO: a push and pop in the same cycle SHALL leave count unchanged; a push when full is impossible by REQ-019.
REQ-025 Shifter: holds a word register and pixels-left count; pixels per word = DW/bpp, bpp latched from MODE_I at each word load only.
REQ-026 On PIX_EN_I with pixels-left=0 and FIFO non-empty: pop word, PIX_O <= its top bpp bits (MSB-first), pixels-left <= DW/bpp-1.
REQ-027 On PIX_EN_I with pixels-left>0: PIX_O <= next bpp bits below the previous pixel, pixels-left decremented.
REQ-028 On PIX_EN_I with pixels-left=0 and FIFO empty: PIX_O <= 0, UNDERRUN_O <= 1 (sticky until FRAME_I or reset).
REQ-029 PIX_O SHALL be registered: valid the cycle after PIX_EN_I, held while PIX_EN_I is low.
REQ-030 FRAME_I and PIX_EN_I together: FRAME_I wins, PIX_O <= 0, no pop.

Reset
REQ-031 RST_I SHALL force STB_O=0, CYC_O=0, ADR_O=0, words-remaining=0, FIFO empty, pixels-left=0, PIX_O=0, UNDERRUN_O=0; RST_I overrides FRAME_I.
REQ-032 Reset mid-transfer SHALL drop STB/CYC in the reset cycle and ignore ACK_I.

Verification
REQ-033 FRAME_I with BASE_I=0x00100, WORDS_I=3, ACK_I tied high, no PIX_EN_I -> exactly 3 reads at 0x00100..0x00102, FIFO count 3, STB_O then stays low.
REQ-034 MODE_I=0, word 0xF0A0 in FIFO, 16 PIX_EN_I pulses -> PIX_O 1,1,1,1,0,0,0,0,1,0,1,0,0,0,0,0.
REQ-035 MODE_I=2, words 0x1234,0xABCD -> PIX_O 1,2,3,4,0xA,0xB,0xC,0xD; MODE_I changed to 0 mid-word takes effect only on the next word.
REQ-036 ACK_I withheld, DEPTH=8, PIX_EN_I every cycle after FRAME_I -> PIX_O=0, UNDERRUN_O=1 one cycle after first PIX_EN_I, stays 1 until next FRAME_I.
REQ-037 ACK_I held high, WORDS_I=20, no PIX_EN_I -> fetching stops at 8 words; one pop (16 PIX_EN_I in 1bpp) -> exactly one further read.
REQ-038 FRAME_I or RST_I asserted while STB_O=1 with coincident ACK_I -> word discarded, FIFO empty, ADR_O=BASE_I (or 0 for reset).
